// File: rtl/sram_bank_array.sv
// ROWS x COLS single-port SRAM banks with a shared address, per-bank cs/we/be and a READ_LATENCY-deep read pipeline.
// An optional zero-fill of every word runs after reset. There is no backpressure: one access per bank per cycle once init_done_o=1.
module sram_bank_array #(
    parameter int unsigned SRAM_BANKS_ROWS      = 1,
    parameter int unsigned SRAM_BANKS_COLS      = 1,
    parameter int unsigned SRAM_BANK_ADDR_WIDTH = 16,
    parameter int unsigned SRAM_BANK_DATA_WIDTH = 32,
    parameter int unsigned READ_LATENCY         = 1,
    parameter int unsigned INIT_ON_RESET        = 1
) (
    input  logic                                                                 clk_i,
    input  logic                                                                 rst_ni,
    input  logic [SRAM_BANK_ADDR_WIDTH-1:0]                                      bank_addr,
    input  logic [SRAM_BANKS_ROWS-1:0][SRAM_BANKS_COLS-1:0]                      bank_cs,
    input  logic [SRAM_BANKS_ROWS-1:0][SRAM_BANKS_COLS-1:0]                      bank_we,
    input  logic [SRAM_BANKS_ROWS-1:0][SRAM_BANKS_COLS-1:0][SRAM_BANK_DATA_WIDTH/8-1:0] bank_be,
    input  logic [SRAM_BANKS_COLS-1:0][SRAM_BANK_DATA_WIDTH-1:0]                 bank_wdata,
    output logic [SRAM_BANKS_ROWS-1:0][SRAM_BANKS_COLS-1:0][SRAM_BANK_DATA_WIDTH-1:0] bank_rdata,
    output logic                                                                 init_done_o
);

    localparam int unsigned AW    = SRAM_BANK_ADDR_WIDTH;
    localparam int unsigned DW    = SRAM_BANK_DATA_WIDTH;
    localparam int unsigned NB    = DW / 8;
    localparam int unsigned DEPTH = 2 ** AW;

    typedef enum logic {
        INIT,
        READY
    } state_t;

    state_t         state_q, state_d;
    logic [AW-1:0]  init_addr_q, init_addr_d;
    logic           access_en;
    logic           init_wr;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q     <= (INIT_ON_RESET != 0) ? INIT : READY;
            init_addr_q <= '0;
        end else begin
            state_q     <= state_d;
            init_addr_q <= init_addr_d;
        end
    end

    // The last word is written in the same cycle the FSM leaves INIT, so the counter never wraps.
    always_comb begin
        state_d     = state_q;
        init_addr_d = init_addr_q;
        if (state_q == INIT) begin
            if (&init_addr_q) begin
                state_d = READY;
            end else begin
                init_addr_d = init_addr_q + AW'(1);
            end
        end
    end

    assign init_done_o = (state_q == READY);
    assign access_en   = rst_ni && (state_q == READY);
    assign init_wr     = rst_ni && (state_q == INIT);

    for (genvar r = 0; r < SRAM_BANKS_ROWS; r++) begin : g_row
        for (genvar c = 0; c < SRAM_BANKS_COLS; c++) begin : g_col
            logic [DW-1:0] mem [DEPTH];
            logic [DW-1:0] rdata_q;
            logic          rd_en;
            logic          wr_en;

            assign rd_en = access_en && bank_cs[r][c] && !bank_we[r][c];
            assign wr_en = access_en && bank_cs[r][c] &&  bank_we[r][c];

            always_ff @(posedge clk_i) begin
                if (init_wr) begin
                    mem[init_addr_q] <= '0;
                end else if (wr_en) begin
                    for (int b = 0; b < NB; b++) begin
                        if (bank_be[r][c][b]) begin
                            mem[bank_addr][b*8 +: 8] <= bank_wdata[c][b*8 +: 8];
                        end
                    end
                end
            end

            if (READ_LATENCY == 1) begin : g_lat1
                always_ff @(posedge clk_i) begin
                    if (!rst_ni) begin
                        rdata_q <= '0;
                    end else if (rd_en) begin
                        rdata_q <= mem[bank_addr];
                    end
                end
            end else begin : g_latn
                // pipe[i]/vld[i] hold a read sampled i+1 edges ago; rdata_q is the final stage.
                logic [READ_LATENCY-2:0] vld;
                logic [DW-1:0]           pipe [READ_LATENCY-1];

                always_ff @(posedge clk_i) begin
                    if (!rst_ni) begin
                        vld     <= '0;
                        rdata_q <= '0;
                    end else begin
                        vld[0] <= rd_en;
                        for (int i = 1; i < READ_LATENCY - 1; i++) begin
                            vld[i] <= vld[i-1];
                        end
                        if (vld[READ_LATENCY-2]) begin
                            rdata_q <= pipe[READ_LATENCY-2];
                        end
                    end
                end

                always_ff @(posedge clk_i) begin
                    if (rd_en) begin
                        pipe[0] <= mem[bank_addr];
                    end
                    for (int i = 1; i < READ_LATENCY - 1; i++) begin
                        if (vld[i-1]) begin
                            pipe[i] <= pipe[i-1];
                        end
                    end
                end
            end

            assign bank_rdata[r][c] = rdata_q;
        end
    end

endmodule

// File: tb/tb_sram_bank_array.sv
// Directed bench for sram_bank_array: 2x2 banks, 16 words of 32 bits, read latency 3, zero-fill on reset.
module tb_sram_bank_array;

    logic                   clk_i = 1'b0;
    logic                   rst_ni;
    logic [3:0]             bank_addr;
    logic [1:0][1:0]        bank_cs;
    logic [1:0][1:0]        bank_we;
    logic [1:0][1:0][3:0]   bank_be;
    logic [1:0][31:0]       bank_wdata;
    logic [1:0][1:0][31:0]  bank_rdata;
    logic                   init_done_o;

    int n_cmp = 0;
    int n_bad = 0;

    sram_bank_array #(
        .SRAM_BANKS_ROWS      (2),
        .SRAM_BANKS_COLS      (2),
        .SRAM_BANK_ADDR_WIDTH (4),
        .SRAM_BANK_DATA_WIDTH (32),
        .READ_LATENCY         (3),
        .INIT_ON_RESET        (1)
    ) dut (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .bank_addr   (bank_addr),
        .bank_cs     (bank_cs),
        .bank_we     (bank_we),
        .bank_be     (bank_be),
        .bank_wdata  (bank_wdata),
        .bank_rdata  (bank_rdata),
        .init_done_o (init_done_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic tick;
        @(posedge clk_i);
        #1;
    endtask

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic wr(input logic [3:0] cs, input logic [3:0] addr, input logic [3:0] be,
                      input logic [31:0] wd0, input logic [31:0] wd1);
        bank_cs    = cs;
        bank_we    = 4'b1111;
        bank_addr  = addr;
        bank_be    = {4{be}};
        bank_wdata = {wd1, wd0};
        tick();
        bank_cs    = '0;
        bank_we    = '0;
    endtask

    task automatic rd(input logic [3:0] cs, input logic [3:0] addr);
        bank_cs   = cs;
        bank_we   = '0;
        bank_addr = addr;
        tick();
        bank_cs   = '0;
    endtask

    initial begin
        rst_ni     = 1'b0;
        bank_addr  = '0;
        bank_cs    = '0;
        bank_we    = '0;
        bank_be    = '0;
        bank_wdata = '0;
        tick();
        tick();
        check("reset_done", 128'(init_done_o), 128'd0);
        check("reset_rdata", bank_rdata, 128'd0);

        // Init with an access pulse that must be ignored (word 2 is already zeroed by edge 5).
        rst_ni = 1'b1;
        for (int e = 1; e <= 16; e++) begin
            if (e == 5) begin
                bank_cs    = '1;
                bank_we    = '1;
                bank_addr  = 4'd2;
                bank_be    = '1;
                bank_wdata = {2{32'hFFFF_FFFF}};
            end
            tick();
            bank_cs = '0;
            bank_we = '0;
            if (e == 8)  check("init_rdata_quiet", bank_rdata, 128'd0);
            if (e == 15) check("init_done_edge15", 128'(init_done_o), 128'd0);
            if (e == 16) check("init_done_edge16", 128'(init_done_o), 128'd1);
        end

        // Stream reads of every word; data for read i appears after the tick for read i+2.
        for (int i = 0; i < 18; i++) begin
            if (i < 16) begin
                bank_cs   = '1;
                bank_addr = 4'(i);
            end else begin
                bank_cs = '0;
            end
            tick();
            if (i >= 2) check($sformatf("zero_word_%0d", i - 2), bank_rdata, 128'd0);
        end
        bank_cs = '0;

        // Byte-enable merge, read immediately after the write.
        wr(4'b1111, 4'd12, 4'hF, 32'hCAFE_F00D, 32'hCAFE_F00D);
        wr(4'b1111, 4'd4, 4'hF, 32'h1122_3344, 32'h1122_3344);
        wr(4'b1111, 4'd4, 4'b0101, 32'hDEAD_BEEF, 32'hDEAD_BEEF);
        rd(4'b1111, 4'd4);
        tick();
        tick();
        check("byte_enable", bank_rdata, {4{32'h11AD_33EF}});

        // Latency 3, back-to-back reads.
        wr(4'b1111, 4'd1, 4'hF, 32'hA, 32'hA);
        wr(4'b1111, 4'd2, 4'hF, 32'hB, 32'hB);
        wr(4'b1111, 4'd3, 4'hF, 32'hC, 32'hC);
        check("lat_write_holds", bank_rdata, {4{32'h11AD_33EF}});
        rd(4'b1111, 4'd1);
        check("lat_k", bank_rdata, {4{32'h11AD_33EF}});
        rd(4'b1111, 4'd2);
        check("lat_k1", bank_rdata, {4{32'h11AD_33EF}});
        rd(4'b1111, 4'd3);
        check("lat_k2_A", bank_rdata, {4{32'hA}});
        tick();
        check("lat_k3_B", bank_rdata, {4{32'hB}});
        tick();
        check("lat_k4_C", bank_rdata, {4{32'hC}});
        tick();
        check("lat_hold1", bank_rdata, {4{32'hC}});
        tick();
        check("lat_hold2", bank_rdata, {4{32'hC}});

        // Row/column select: row 1 only, distinct column data.
        wr(4'b1111, 4'd6, 4'hF, 32'h77, 32'h77);
        wr(4'b1100, 4'd6, 4'hF, 32'h55, 32'h66);
        rd(4'b1111, 4'd6);
        tick();
        tick();
        check("rowcol_read", bank_rdata, {32'h66, 32'h55, 32'h77, 32'h77});
        rd(4'b1000, 4'd1);
        tick();
        tick();
        check("single_bank_read", bank_rdata, {32'hA, 32'h55, 32'h77, 32'h77});

        // Read, then write the same address, then read again.
        wr(4'b1111, 4'd5, 4'hF, 32'h1, 32'h1);
        rd(4'b1111, 4'd5);
        wr(4'b1111, 4'd5, 4'hF, 32'h2, 32'h2);
        check("hazard_write_no_rdata", bank_rdata, {32'hA, 32'h55, 32'h77, 32'h77});
        rd(4'b1111, 4'd5);
        check("hazard_old_data", bank_rdata, {4{32'h1}});
        tick();
        check("hazard_old_hold", bank_rdata, {4{32'h1}});
        tick();
        check("hazard_new_data", bank_rdata, {4{32'h2}});

        // Reset with two reads in flight: they must be dropped.
        rd(4'b1111, 4'd1);
        rd(4'b1111, 4'd2);
        rst_ni = 1'b0;
        tick();
        check("inflight_reset_rdata", bank_rdata, 128'd0);
        check("inflight_reset_done", 128'(init_done_o), 128'd0);
        rst_ni = 1'b1;
        for (int e = 1; e <= 7; e++) begin
            tick();
            if (e <= 2) check($sformatf("inflight_dropped_%0d", e), bank_rdata, 128'd0);
        end

        // Reset again with init_addr at 7: INIT restarts and takes the full 16 edges.
        rst_ni = 1'b0;
        tick();
        rst_ni = 1'b1;
        for (int e = 1; e <= 16; e++) begin
            tick();
            if (e == 9)  check("restart_done_edge9", 128'(init_done_o), 128'd0);
            if (e == 15) check("restart_done_edge15", 128'(init_done_o), 128'd0);
            if (e == 16) check("restart_done_edge16", 128'(init_done_o), 128'd1);
        end

        rd(4'b1111, 4'd12);
        rd(4'b1111, 4'd5);
        tick();
        check("refill_word12", bank_rdata, 128'd0);
        tick();
        check("refill_word5", bank_rdata, 128'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
